// File: rtl/sdp_ew_operand_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : sdp_ew_operand_unpack
//  Purpose  : Unpacks 64-bit EW read-DMA beats into per-element ALU and MUL
//             operand streams. Supports ALU-only, MUL-only and interleaved
//             ALU+MUL layouts. The two streams handshake independently.
//             Elements are counted per layer, padding past the layer end is
//             dropped, and layer_done pulses once per layer.
//  Revision : 1.0  initial release
// ============================================================================
module sdp_ew_operand_unpack #(
   parameter int ELEM_W = 16
) (
   input  logic                nvdla_core_clk,
   input  logic                nvdla_core_rstn,
   input  logic                op_en_load,
   input  logic                reg2dp_ew_alu_bypass,
   input  logic                reg2dp_ew_alu_src,
   input  logic                reg2dp_ew_mul_bypass,
   input  logic                reg2dp_ew_mul_src,
   input  logic [31:0]         reg2dp_ew_elem_num,
   input  logic [4*ELEM_W-1:0] dma_rd_pd,
   input  logic                dma_rd_pvld,
   output logic                dma_rd_prdy,
   output logic [ELEM_W-1:0]   ew_alu_in_data,
   output logic                ew_alu_in_vld,
   input  logic                ew_alu_in_rdy,
   output logic [ELEM_W-1:0]   ew_mul_in_data,
   output logic                ew_mul_in_vld,
   input  logic                ew_mul_in_rdy,
   output logic                layer_done
);

   localparam int BEAT_W = 4 * ELEM_W;

   // Captured configuration
   logic              cfg_alu_bypass;
   logic              cfg_alu_src;
   logic              cfg_mul_bypass;
   logic              cfg_mul_src;
   logic [31:0]       cfg_elem_num;

   // Beat / slot state
   logic [BEAT_W-1:0] beat_q;
   logic              beat_vld;
   logic [1:0]        slot_ptr;
   logic              alu_done;
   logic              mul_done;
   logic [31:0]       elem_cnt;

   // Derived control
   logic              alu_en;
   logic              mul_en;
   logic              both_en;
   logic              any_en;
   logic              alu_hs;
   logic              mul_hs;
   logic              alu_ok;
   logic              mul_ok;
   logic              slot_cmp;
   logic              last_slot;
   logic              layer_end;
   logic              beat_rel;
   logic              beat_acc;

   assign alu_en  = cfg_alu_src & ~cfg_alu_bypass;
   assign mul_en  = cfg_mul_src & ~cfg_mul_bypass;
   assign both_en = alu_en & mul_en;
   assign any_en  = alu_en | mul_en;

   // A stream's vld drops once it has taken its element of the current slot
   assign ew_alu_in_vld = beat_vld & alu_en & ~alu_done;
   assign ew_mul_in_vld = beat_vld & mul_en & ~mul_done;

   assign alu_hs = ew_alu_in_vld & ew_alu_in_rdy;
   assign mul_hs = ew_mul_in_vld & ew_mul_in_rdy;

   // A stream is satisfied for this slot if disabled, already taken, or taking now
   assign alu_ok = ~alu_en | alu_done | alu_hs;
   assign mul_ok = ~mul_en | mul_done | mul_hs;

   assign slot_cmp  = beat_vld & any_en & alu_ok & mul_ok;
   assign last_slot = both_en ? (slot_ptr == 2'd1) : (slot_ptr == 2'd3);
   assign layer_end = slot_cmp & (elem_cnt == cfg_elem_num);
   assign beat_rel  = slot_cmp & (last_slot | layer_end);

   // Accept a new beat when empty or when the held beat retires this cycle
   assign dma_rd_prdy = any_en & (~beat_vld | beat_rel);
   assign beat_acc    = dma_rd_prdy & dma_rd_pvld;

   // Select the element fields of the current slot for each stream
   always_comb begin
      ew_alu_in_data = '0;
      ew_mul_in_data = '0;
      if (both_en) begin
         if (slot_ptr[0]) begin
            ew_alu_in_data = beat_q[2*ELEM_W +: ELEM_W];
            ew_mul_in_data = beat_q[3*ELEM_W +: ELEM_W];
         end else begin
            ew_alu_in_data = beat_q[0 +: ELEM_W];
            ew_mul_in_data = beat_q[ELEM_W +: ELEM_W];
         end
      end else begin
         case (slot_ptr)
            2'd0:    ew_alu_in_data = beat_q[0 +: ELEM_W];
            2'd1:    ew_alu_in_data = beat_q[ELEM_W +: ELEM_W];
            2'd2:    ew_alu_in_data = beat_q[2*ELEM_W +: ELEM_W];
            default: ew_alu_in_data = beat_q[3*ELEM_W +: ELEM_W];
         endcase
         ew_mul_in_data = ew_alu_in_data;
      end
   end

   // Configuration capture on layer load
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         cfg_alu_bypass <= 1'b0;
         cfg_alu_src    <= 1'b0;
         cfg_mul_bypass <= 1'b0;
         cfg_mul_src    <= 1'b0;
         cfg_elem_num   <= '0;
      end else if (op_en_load) begin
         cfg_alu_bypass <= reg2dp_ew_alu_bypass;
         cfg_alu_src    <= reg2dp_ew_alu_src;
         cfg_mul_bypass <= reg2dp_ew_mul_bypass;
         cfg_mul_src    <= reg2dp_ew_mul_src;
         cfg_elem_num   <= reg2dp_ew_elem_num;
      end
   end

   // Beat holding register: load on accept, empty when the beat retires
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         beat_q   <= '0;
         beat_vld <= 1'b0;
      end else if (beat_acc) begin
         beat_q   <= dma_rd_pd;
         beat_vld <= 1'b1;
      end else if (beat_rel) begin
         beat_vld <= 1'b0;
      end
   end

   // Slot pointer, per-stream done bits and per-layer element counter
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         slot_ptr <= 2'd0;
         alu_done <= 1'b0;
         mul_done <= 1'b0;
         elem_cnt <= '0;
      end else if (op_en_load) begin
         slot_ptr <= 2'd0;
         alu_done <= 1'b0;
         mul_done <= 1'b0;
         elem_cnt <= '0;
      end else begin
         if (slot_cmp) begin
            alu_done <= 1'b0;
            mul_done <= 1'b0;
         end else begin
            if (alu_hs) alu_done <= 1'b1;
            if (mul_hs) mul_done <= 1'b1;
         end

         if (layer_end)     elem_cnt <= '0;
         else if (slot_cmp) elem_cnt <= elem_cnt + 32'd1;

         if (beat_acc || beat_rel) slot_ptr <= 2'd0;
         else if (slot_cmp)        slot_ptr <= slot_ptr + 2'd1;
      end
   end

   // Layer completion pulse, one cycle after the final element retires
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) layer_done <= 1'b0;
      else                  layer_done <= layer_end & ~op_en_load;
   end

endmodule
`default_nettype wire

// File: tb/tb_sdp_ew_operand_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdp_ew_operand_unpack
//  Purpose  : Self-checking bench for sdp_ew_operand_unpack. Expected operand
//             elements are queued when beats are scheduled and compared as the
//             DUT hands them off; scenario tasks check timing points inline.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdp_ew_operand_unpack;

   logic        nvdla_core_clk;
   logic        nvdla_core_rstn;
   logic        op_en_load;
   logic        reg2dp_ew_alu_bypass;
   logic        reg2dp_ew_alu_src;
   logic        reg2dp_ew_mul_bypass;
   logic        reg2dp_ew_mul_src;
   logic [31:0] reg2dp_ew_elem_num;
   logic [63:0] dma_rd_pd;
   logic        dma_rd_pvld;
   logic        dma_rd_prdy;
   logic [15:0] ew_alu_in_data;
   logic        ew_alu_in_vld;
   logic        ew_alu_in_rdy;
   logic [15:0] ew_mul_in_data;
   logic        ew_mul_in_vld;
   logic        ew_mul_in_rdy;
   logic        layer_done;

   sdp_ew_operand_unpack #(.ELEM_W(16)) dut (
      .nvdla_core_clk       (nvdla_core_clk),
      .nvdla_core_rstn      (nvdla_core_rstn),
      .op_en_load           (op_en_load),
      .reg2dp_ew_alu_bypass (reg2dp_ew_alu_bypass),
      .reg2dp_ew_alu_src    (reg2dp_ew_alu_src),
      .reg2dp_ew_mul_bypass (reg2dp_ew_mul_bypass),
      .reg2dp_ew_mul_src    (reg2dp_ew_mul_src),
      .reg2dp_ew_elem_num   (reg2dp_ew_elem_num),
      .dma_rd_pd            (dma_rd_pd),
      .dma_rd_pvld          (dma_rd_pvld),
      .dma_rd_prdy          (dma_rd_prdy),
      .ew_alu_in_data       (ew_alu_in_data),
      .ew_alu_in_vld        (ew_alu_in_vld),
      .ew_alu_in_rdy        (ew_alu_in_rdy),
      .ew_mul_in_data       (ew_mul_in_data),
      .ew_mul_in_vld        (ew_mul_in_vld),
      .ew_mul_in_rdy        (ew_mul_in_rdy),
      .layer_done           (layer_done)
   );

   initial nvdla_core_clk = 1'b0;
   always #5 nvdla_core_clk = ~nvdla_core_clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [63:0] beat_src[$];
   logic [15:0] alu_exp[$];
   logic [15:0] mul_exp[$];

   int alu_hs_cnt;
   int mul_hs_cnt;
   int alu_first;
   int alu_last;
   int ld_cnt;
   int ld_cyc;
   int mul_vld_cnt;

   logic [15:0] mon_exp;
   logic        alu_stall_q = 1'b0;
   logic        mul_stall_q = 1'b0;
   logic [15:0] alu_data_q;
   logic [15:0] mul_data_q;

   always @(posedge nvdla_core_clk) cyc <= cyc + 1;

   // Scoreboard monitor: compares every handshaken element against the queues
   always @(negedge nvdla_core_clk) begin
      if (ew_alu_in_vld && ew_alu_in_rdy) begin
         checks++;
         if (alu_exp.size() == 0) begin
            errors++;
            $display("FAIL alu_extra got=%h expected=none", ew_alu_in_data);
         end else begin
            mon_exp = alu_exp.pop_front();
            if (ew_alu_in_data !== mon_exp) begin
               errors++;
               $display("FAIL alu_data got=%h expected=%h", ew_alu_in_data, mon_exp);
            end
         end
         if (alu_hs_cnt == 0) alu_first = cyc;
         alu_last = cyc;
         alu_hs_cnt++;
      end
      if (ew_mul_in_vld && ew_mul_in_rdy) begin
         checks++;
         if (mul_exp.size() == 0) begin
            errors++;
            $display("FAIL mul_extra got=%h expected=none", ew_mul_in_data);
         end else begin
            mon_exp = mul_exp.pop_front();
            if (ew_mul_in_data !== mon_exp) begin
               errors++;
               $display("FAIL mul_data got=%h expected=%h", ew_mul_in_data, mon_exp);
            end
         end
         mul_hs_cnt++;
      end
      if (ew_mul_in_vld) mul_vld_cnt++;
      if (layer_done) begin
         ld_cnt++;
         ld_cyc = cyc;
      end
      // A stalled element must stay valid with unchanged data
      if (nvdla_core_rstn && alu_stall_q) begin
         checks++;
         if (ew_alu_in_vld !== 1'b1 || ew_alu_in_data !== alu_data_q) begin
            errors++;
            $display("FAIL alu_hold got vld=%b data=%h expected vld=1 data=%h",
                     ew_alu_in_vld, ew_alu_in_data, alu_data_q);
         end
      end
      if (nvdla_core_rstn && mul_stall_q) begin
         checks++;
         if (ew_mul_in_vld !== 1'b1 || ew_mul_in_data !== mul_data_q) begin
            errors++;
            $display("FAIL mul_hold got vld=%b data=%h expected vld=1 data=%h",
                     ew_mul_in_vld, ew_mul_in_data, mul_data_q);
         end
      end
      alu_stall_q = nvdla_core_rstn && ew_alu_in_vld && !ew_alu_in_rdy;
      mul_stall_q = nvdla_core_rstn && ew_mul_in_vld && !ew_mul_in_rdy;
      alu_data_q  = ew_alu_in_data;
      mul_data_q  = ew_mul_in_data;
   end

   task automatic clear_stats();
      alu_hs_cnt  = 0;
      mul_hs_cnt  = 0;
      alu_first   = 0;
      alu_last    = 0;
      ld_cnt      = 0;
      ld_cyc      = 0;
      mul_vld_cnt = 0;
   endtask

   task automatic load_cfg(input logic abyp, input logic asrc, input logic mbyp,
                           input logic msrc, input logic [31:0] num);
      reg2dp_ew_alu_bypass = abyp;
      reg2dp_ew_alu_src    = asrc;
      reg2dp_ew_mul_bypass = mbyp;
      reg2dp_ew_mul_src    = msrc;
      reg2dp_ew_elem_num   = num;
      op_en_load           = 1'b1;
      @(posedge nvdla_core_clk); #1;
      op_en_load           = 1'b0;
   endtask

   // Offers each scheduled beat until accepted
   task automatic drive_beats();
      logic acc;
      int   guard;
      guard = 0;
      while (beat_src.size() > 0 && guard < 200) begin
         dma_rd_pd   = beat_src[0];
         dma_rd_pvld = 1'b1;
         @(negedge nvdla_core_clk);
         acc = dma_rd_prdy;
         @(posedge nvdla_core_clk); #1;
         if (acc) void'(beat_src.pop_front());
         guard++;
      end
      dma_rd_pvld = 1'b0;
      checks++;
      if (beat_src.size() != 0) begin
         errors++;
         $display("FAIL drive_timeout got pending=%0d expected=0", beat_src.size());
         beat_src.delete();
      end
   endtask

   task automatic wait_drain(input string name);
      int guard;
      guard = 0;
      while ((alu_exp.size() != 0 || mul_exp.size() != 0) && guard < 100) begin
         @(posedge nvdla_core_clk); #1;
         guard++;
      end
      repeat (3) begin
         @(posedge nvdla_core_clk); #1;
      end
      checks++;
      if (alu_exp.size() != 0 || mul_exp.size() != 0) begin
         errors++;
         $display("FAIL %s_drain got alu_left=%0d mul_left=%0d expected=0/0",
                  name, alu_exp.size(), mul_exp.size());
         alu_exp.delete();
         mul_exp.delete();
      end
   endtask

   task automatic test_reset();
      @(negedge nvdla_core_clk);
      checks++;
      if (dma_rd_prdy !== 1'b0 || ew_alu_in_vld !== 1'b0 || ew_mul_in_vld !== 1'b0 ||
          ew_alu_in_data !== 16'h0 || ew_mul_in_data !== 16'h0 || layer_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got prdy=%b av=%b mv=%b ad=%h md=%h ld=%b expected all 0",
                  dma_rd_prdy, ew_alu_in_vld, ew_mul_in_vld, ew_alu_in_data,
                  ew_mul_in_data, layer_done);
      end
      @(posedge nvdla_core_clk); #1;
   endtask

   task automatic test_alu_only();
      clear_stats();
      load_cfg(1'b0, 1'b1, 1'b1, 1'b0, 32'd7);
      for (int i = 1; i <= 8; i++) alu_exp.push_back(16'(i));
      beat_src.push_back(64'h0004_0003_0002_0001);
      beat_src.push_back(64'h0008_0007_0006_0005);
      drive_beats();
      wait_drain("alu_only");
      checks++;
      if (alu_hs_cnt != 8 || (alu_last - alu_first) != 7) begin
         errors++;
         $display("FAIL alu_only_rate got count=%0d span=%0d expected count=8 span=7",
                  alu_hs_cnt, alu_last - alu_first);
      end
      checks++;
      if (ld_cnt != 1 || ld_cyc != alu_last + 1) begin
         errors++;
         $display("FAIL alu_only_layer_done got pulses=%0d at=%0d expected pulses=1 at=%0d",
                  ld_cnt, ld_cyc, alu_last + 1);
      end
      checks++;
      if (mul_vld_cnt != 0) begin
         errors++;
         $display("FAIL alu_only_mul_vld got=%0d expected=0", mul_vld_cnt);
      end
   endtask

   task automatic test_both();
      clear_stats();
      load_cfg(1'b0, 1'b1, 1'b0, 1'b1, 32'd1);
      alu_exp.push_back(16'h1111); alu_exp.push_back(16'hAAAA);
      mul_exp.push_back(16'h2222); mul_exp.push_back(16'hBBBB);
      beat_src.push_back(64'hBBBB_AAAA_2222_1111);
      fork
         drive_beats();
         begin
            int guard;
            guard = 0;
            do begin
               @(negedge nvdla_core_clk);
               guard++;
            end while (!ew_alu_in_vld && guard < 20);
            checks++;
            if (ew_mul_in_vld !== 1'b1 || ew_alu_in_data !== 16'h1111 ||
                ew_mul_in_data !== 16'h2222 || dma_rd_prdy !== 1'b0) begin
               errors++;
               $display("FAIL both_slot0 got mv=%b ad=%h md=%h prdy=%b expected 1/1111/2222/0",
                        ew_mul_in_vld, ew_alu_in_data, ew_mul_in_data, dma_rd_prdy);
            end
            @(negedge nvdla_core_clk);
            checks++;
            if (ew_alu_in_vld !== 1'b1 || ew_mul_in_vld !== 1'b1 ||
                ew_alu_in_data !== 16'hAAAA || ew_mul_in_data !== 16'hBBBB ||
                dma_rd_prdy !== 1'b1) begin
               errors++;
               $display("FAIL both_slot1 got av=%b mv=%b ad=%h md=%h prdy=%b expected 1/1/AAAA/BBBB/1",
                        ew_alu_in_vld, ew_mul_in_vld, ew_alu_in_data, ew_mul_in_data, dma_rd_prdy);
            end
            @(posedge nvdla_core_clk); #1;
         end
      join
      wait_drain("both");
      checks++;
      if (ld_cnt != 1) begin
         errors++;
         $display("FAIL both_layer_done got=%0d expected=1", ld_cnt);
      end
   endtask

   task automatic test_independent_stall();
      clear_stats();
      load_cfg(1'b0, 1'b1, 1'b0, 1'b1, 32'd1);
      alu_exp.push_back(16'h1111); alu_exp.push_back(16'hAAAA);
      mul_exp.push_back(16'h2222); mul_exp.push_back(16'hBBBB);
      beat_src.push_back(64'hBBBB_AAAA_2222_1111);
      ew_mul_in_rdy = 1'b0;
      fork
         drive_beats();
         begin
            int guard;
            guard = 0;
            do begin
               @(negedge nvdla_core_clk);
               guard++;
            end while (!ew_alu_in_vld && guard < 20);
            checks++;
            if (ew_mul_in_vld !== 1'b1 || ew_mul_in_data !== 16'h2222) begin
               errors++;
               $display("FAIL stall_first got mv=%b md=%h expected 1/2222",
                        ew_mul_in_vld, ew_mul_in_data);
            end
            repeat (2) begin
               @(negedge nvdla_core_clk);
               checks++;
               if (ew_alu_in_vld !== 1'b0 || ew_mul_in_vld !== 1'b1) begin
                  errors++;
                  $display("FAIL stall_hold got av=%b mv=%b expected 0/1",
                           ew_alu_in_vld, ew_mul_in_vld);
               end
            end
            @(posedge nvdla_core_clk); #1;
            ew_mul_in_rdy = 1'b1;
            @(negedge nvdla_core_clk);
            checks++;
            if (ew_alu_in_vld !== 1'b0 || ew_mul_in_vld !== 1'b1 ||
                ew_mul_in_data !== 16'h2222) begin
               errors++;
               $display("FAIL stall_release got av=%b mv=%b md=%h expected 0/1/2222",
                        ew_alu_in_vld, ew_mul_in_vld, ew_mul_in_data);
            end
            @(negedge nvdla_core_clk);
            checks++;
            if (ew_alu_in_vld !== 1'b1 || ew_mul_in_vld !== 1'b1 ||
                ew_alu_in_data !== 16'hAAAA || ew_mul_in_data !== 16'hBBBB) begin
               errors++;
               $display("FAIL stall_slot1 got av=%b mv=%b ad=%h md=%h expected 1/1/AAAA/BBBB",
                        ew_alu_in_vld, ew_mul_in_vld, ew_alu_in_data, ew_mul_in_data);
            end
            @(posedge nvdla_core_clk); #1;
         end
      join
      wait_drain("stall");
      checks++;
      if (alu_hs_cnt != 2 || mul_hs_cnt != 2) begin
         errors++;
         $display("FAIL stall_counts got alu=%0d mul=%0d expected 2/2", alu_hs_cnt, mul_hs_cnt);
      end
   endtask

   task automatic test_mul_layer_end();
      clear_stats();
      load_cfg(1'b1, 1'b0, 1'b0, 1'b1, 32'd5);
      for (int i = 1; i <= 6; i++) mul_exp.push_back(16'(i));
      for (int i = 9; i <= 12; i++) mul_exp.push_back(16'(i));
      beat_src.push_back(64'h0004_0003_0002_0001);
      beat_src.push_back(64'h0008_0007_0006_0005);
      beat_src.push_back(64'h000C_000B_000A_0009);
      fork
         drive_beats();
         begin
            int guard;
            guard = 0;
            do begin
               @(negedge nvdla_core_clk);
               guard++;
            end while (!(ew_mul_in_vld && ew_mul_in_data == 16'h0006) && guard < 40);
            checks++;
            if (dma_rd_prdy !== 1'b1 || ew_mul_in_data !== 16'h0006) begin
               errors++;
               $display("FAIL mul_end_prdy got prdy=%b md=%h expected 1/0006",
                        dma_rd_prdy, ew_mul_in_data);
            end
            @(negedge nvdla_core_clk);
            checks++;
            if (layer_done !== 1'b1 || ew_mul_in_vld !== 1'b1 || ew_mul_in_data !== 16'h0009) begin
               errors++;
               $display("FAIL mul_end_next got ld=%b mv=%b md=%h expected 1/1/0009",
                        layer_done, ew_mul_in_vld, ew_mul_in_data);
            end
            @(posedge nvdla_core_clk); #1;
         end
      join
      wait_drain("mul_end");
      checks++;
      if (ld_cnt != 1 || mul_hs_cnt != 10 || alu_hs_cnt != 0) begin
         errors++;
         $display("FAIL mul_end_counts got ld=%0d mul=%0d alu=%0d expected 1/10/0",
                  ld_cnt, mul_hs_cnt, alu_hs_cnt);
      end
   endtask

   task automatic test_bypass();
      clear_stats();
      load_cfg(1'b1, 1'b1, 1'b1, 1'b1, 32'd0);
      dma_rd_pd   = 64'h1234_5678_9ABC_DEF0;
      dma_rd_pvld = 1'b1;
      repeat (5) begin
         @(negedge nvdla_core_clk);
         checks++;
         if (dma_rd_prdy !== 1'b0 || ew_alu_in_vld !== 1'b0 ||
             ew_mul_in_vld !== 1'b0 || layer_done !== 1'b0) begin
            errors++;
            $display("FAIL bypass_idle got prdy=%b av=%b mv=%b ld=%b expected 0/0/0/0",
                     dma_rd_prdy, ew_alu_in_vld, ew_mul_in_vld, layer_done);
         end
      end
      @(posedge nvdla_core_clk); #1;
      dma_rd_pvld = 1'b0;
   endtask

   task automatic test_reset_mid_beat();
      int guard;
      clear_stats();
      load_cfg(1'b0, 1'b1, 1'b1, 1'b0, 32'd7);
      for (int i = 1; i <= 4; i++) alu_exp.push_back(16'(i));
      beat_src.push_back(64'h0004_0003_0002_0001);
      drive_beats();
      guard = 0;
      while (alu_hs_cnt < 2 && guard < 20) begin
         @(posedge nvdla_core_clk); #1;
         guard++;
      end
      nvdla_core_rstn = 1'b0;
      alu_exp.delete();
      @(negedge nvdla_core_clk);
      checks++;
      if (alu_hs_cnt != 2 || dma_rd_prdy !== 1'b0 || ew_alu_in_vld !== 1'b0 ||
          ew_mul_in_vld !== 1'b0 || ew_alu_in_data !== 16'h0 ||
          ew_mul_in_data !== 16'h0 || layer_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got hs=%0d prdy=%b av=%b mv=%b ad=%h md=%h ld=%b expected 2 and all 0",
                  alu_hs_cnt, dma_rd_prdy, ew_alu_in_vld, ew_mul_in_vld,
                  ew_alu_in_data, ew_mul_in_data, layer_done);
      end
      @(posedge nvdla_core_clk); #1;
      nvdla_core_rstn = 1'b1;
      @(posedge nvdla_core_clk); #1;
      clear_stats();
      load_cfg(1'b0, 1'b1, 1'b1, 1'b0, 32'd3);
      alu_exp.push_back(16'h0011); alu_exp.push_back(16'h0022);
      alu_exp.push_back(16'h0033); alu_exp.push_back(16'h0044);
      beat_src.push_back(64'h0044_0033_0022_0011);
      drive_beats();
      wait_drain("after_reset");
      checks++;
      if (alu_hs_cnt != 4 || ld_cnt != 1 || ld_cyc != alu_last + 1) begin
         errors++;
         $display("FAIL after_reset_layer got hs=%0d ld=%0d at=%0d expected 4/1 at=%0d",
                  alu_hs_cnt, ld_cnt, ld_cyc, alu_last + 1);
      end
   endtask

   initial begin
      nvdla_core_rstn      = 1'b0;
      op_en_load           = 1'b0;
      reg2dp_ew_alu_bypass = 1'b0;
      reg2dp_ew_alu_src    = 1'b0;
      reg2dp_ew_mul_bypass = 1'b0;
      reg2dp_ew_mul_src    = 1'b0;
      reg2dp_ew_elem_num   = 32'd0;
      dma_rd_pd            = 64'h0;
      dma_rd_pvld          = 1'b0;
      ew_alu_in_rdy        = 1'b1;
      ew_mul_in_rdy        = 1'b1;
      clear_stats();
      repeat (3) @(posedge nvdla_core_clk);
      #1;
      nvdla_core_rstn = 1'b1;

      test_reset();
      test_alu_only();
      test_both();
      test_independent_stall();
      test_mul_layer_end();
      test_bypass();
      test_reset_mid_beat();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sdp_ew_operand_unpack.md
# sdp_ew_operand_unpack

Unpacks 64-bit element-wise operand beats returned by the SDP EW read-DMA into the per-element ALU and MUL operand streams consumed by the SDP Y core's `ew_alu_in_*` / `ew_mul_in_*` ports. It supports three layouts: ALU-only, MUL-only, or interleaved ALU+MUL. The two output streams handshake independently. It counts elements per layer, drops padding past the layer end, and pulses `layer_done`.

## Interface
- ELEM_W, 16, operand element width (fixed; DMA beat = 4*ELEM_W = 64)
- nvdla_core_clk  in  1  clock
- nvdla_core_rstn  in  1  reset; asynchronous, active-low
- op_en_load  in  1  capture reg2dp_* into cfg_* registers; clear counter/slot state
- reg2dp_ew_alu_bypass  in  1  1 = ALU stage bypassed
- reg2dp_ew_alu_src  in  1  1 = ALU operand from memory
- reg2dp_ew_mul_bypass  in  1  1 = MUL stage bypassed
- reg2dp_ew_mul_src  in  1  1 = MUL operand from memory
- reg2dp_ew_elem_num  in  32  elements per layer minus one
- dma_rd_pd  in  64  operand beat
- dma_rd_pvld  in  1  beat valid
- dma_rd_prdy  out  1  beat accepted
- ew_alu_in_data  out  16  ALU operand element
- ew_alu_in_vld  out  1  ALU element valid
- ew_alu_in_rdy  in  1  ALU element ready
- ew_mul_in_data  out  16  MUL operand element
- ew_mul_in_vld  out  1  MUL element valid
- ew_mul_in_rdy  in  1  MUL element ready
- layer_done  out  1  one-cycle pulse after the last element of the layer is fully consumed

## Operation
**Stream enables** (from captured cfg): alu_en = src & !bypass; mul_en = src & !bypass.

**Beat layout**
- One stream enabled: 4 slots. Slot k = pd[16k+15:16k].
- BOTH enabled: 2 slots. Slot k alu = pd[32k+15:32k]; mul = pd[32k+31:32k+16].
- Neither enabled: dma_rd_prdy=0, both vld=0, no layer_done.

**State**
- beat_q[63:0], beat_vld, slot_ptr[1:0], alu_done, mul_done, elem_cnt[31:0].
- cfg registers reset to 0 (both streams disabled, elem_num=0).

**Outputs**
- ew_alu_in_vld = beat_vld & alu_en & !alu_done. Data = ALU field of slot_ptr. Same rule for MUL.

**Slot completion**
- A slot completes when every enabled stream has handshaken its element, simultaneously or in different cycles.
- alu_done / mul_done set on an early handshake and hold the stream's vld low until the slot completes, then clear.

**Slot advance**
- On completion, elem_cnt increments and slot_ptr advances.
- The beat is released when the last slot completes (slot 3 single-stream, slot 1 BOTH) or when elem_cnt == cfg_elem_num (layer end; remaining slots are discarded).
- At layer end, elem_cnt and slot_ptr clear and layer_done pulses the next cycle.

**DMA handshake**
- dma_rd_prdy = enabled & (!beat_vld | beat released this cycle).
- Accept loads beat_q, sets beat_vld, sets slot_ptr=0.

**op_en_load**
- Software asserts it only when idle (beat_vld=0).
- It clears elem_cnt, slot_ptr, and the done bits.

## Timing
- All outputs reset to 0: dma_rd_prdy, both vld, both data, layer_done.
- Latency: beat accepted at cycle N → first element vld at N+1.
- Throughput: 1 element/cycle per stream with no inter-beat bubble. A new beat is accepted in the same cycle the last slot completes.
- Single-stream: 4 cycles per beat. BOTH: 2 cycles per beat.
- vld is never retracted and data is stable while vld=1 & rdy=0.
- Independent stall: if ALU is ready and MUL is not, the ALU element is taken once; ALU vld stays 0 until the MUL element of the same slot is taken.
- Layer end mid-beat: a beat holding 1–3 valid elements is dropped after the last valid element. The next layer's beat is accepted the same cycle if dma_rd_pvld=1.
- Reset mid-beat: beat, counter and cfg are discarded immediately.

## Test plan
- ALU-only, elem_num=7, two beats 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005, rdy=1 → ALU data 1..8 on 8 consecutive cycles, mul_vld=0, layer_done one cycle after element 8.
- BOTH, beat 0xBBBB_AAAA_2222_1111, both rdy=1 → cycle 1 alu=0x1111/mul=0x2222, cycle 2 alu=0xAAAA/mul=0xBBBB, dma_rd_prdy=1 in cycle 2.
- BOTH, mul_rdy=0 for 3 cycles then 1 → alu 0x1111 taken once, alu_vld low until mul 0x2222 taken, then slot 1 presented together.
- MUL-only, elem_num=5 → second beat yields 2 elements, slots 2–3 dropped, layer_done pulses, next beat accepted without a bubble.
- Both streams bypassed, dma_rd_pvld=1 → dma_rd_prdy=0, no vld, no layer_done.
- Assert reset while a beat is half-consumed → all outputs 0 next cycle; after op_en_load the new layer starts at slot 0 with elem_cnt=0.
